key_entry: RTL and testbench
============================

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter DEB_PULSES, default 2: matching key-present pulses required to accept a key (range 1..7).
REQ-002 Parameter REL_CYCLES, default 8: consecutive clk cycles with no key-present pulse that signal release (range 5..15).
REQ-003 clk  input  1  scan clock, 100 Hz. This is the same clock as the keypad scanner; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 digito  input  5  key code from the scanner. Values 0..15 are keys; 16 means no key.
REQ-006 cambio_digito  input  1  key-present strobe from the scanner. While a key is held it is high one cycle in every four.
REQ-007 key_valid  output  1  one-cycle pulse marking an accepted (debounced) key press.
REQ-008 key_code  output  4  code of the last accepted key. It is held between presses.
REQ-009 value  output  16  BCD entry buffer, 4 digits, least-significant digit in [3:0].
REQ-010 num_digits  output  3  number of digits in the buffer, 0..4.
REQ-011 overflow  output  1  sticky flag: a digit was entered while the buffer was full.
REQ-012 value_out  output  16  last committed BCD value.
REQ-013 value_valid  output  1  one-cycle pulse when value_out updates.

Function
REQ-014 A pulse is a cycle with cambio_digito=1 and digito<=15. A cycle with cambio_digito=1 and digito=16 is treated as no pulse.
REQ-015 Debounce FSM states: IDLE, CONFIRM, HELD.
REQ-016 IDLE: a pulse loads cand=digito[3:0], sets match count=1 and enters CONFIRM. If DEB_PULSES=1, the FSM enters HELD directly and accepts the key.
REQ-017 CONFIRM, pulse with digito==cand: increment the count. When the count reaches DEB_PULSES, enter HELD and accept the key.
REQ-018 CONFIRM, pulse with digito!=cand: reload cand with the new code and set count=1. Nothing is accepted.
REQ-019 Idle counter: cleared on every pulse and incremented on every non-pulse cycle, saturating at REL_CYCLES. In CONFIRM or HELD, reaching REL_CYCLES returns the FSM to IDLE (glitch rejected, or release).
REQ-020 HELD: pulses are ignored, including pulses with a different code. There is no auto-repeat. A new key is accepted only after passing through IDLE.
REQ-021 Accept: key_valid=1 for exactly the one cycle after the edge that sampled the accepting pulse. key_code=cand is updated on that same edge, and the buffer actions below are registered on that same edge.
REQ-022 Buffer action, code 0..9 with num_digits<4: value <= {value[11:0], code} and num_digits increments.
REQ-023 Buffer action, code 0..9 with num_digits==4: the digit is discarded, value is unchanged and overflow<=1.
REQ-024 Buffer action, code E (enter) with num_digits>0: value_out<=value and value_valid=1 for one cycle (same cycle as key_valid). Then value<=0, num_digits<=0 and overflow<=0.
REQ-025 Buffer action, code E with num_digits==0: no change, and value_valid stays 0.
REQ-026 Buffer action, code F (clear): value<=0, num_digits<=0, overflow<=0. value_out is unchanged and no value_valid.
REQ-027 Buffer action, codes A..D: key_valid and key_code update only; the buffer is unchanged.
REQ-028 value_out holds until the next successful enter.
REQ-029 A pulse arriving in the same cycle that the idle counter hits REL_CYCLES is processed as a pulse in IDLE: the counter clears and the FSM goes to CONFIRM.

Reset
REQ-030 While rst_n=0, asynchronously set: FSM=IDLE, cand=0, count=0, idle counter=0, key_valid=0, key_code=0, value=0, num_digits=0, overflow=0, value_out=0, value_valid=0.
REQ-031 A reset asserted mid-confirm or mid-hold discards the pending key. After release of reset, a key still held is re-debounced from IDLE and accepted once.
REQ-032 No output pulses on the first clk edge after rst_n rises unless that edge samples an accepting pulse.

Verification
REQ-033 Key 5 held, pulses at cycles 0,4,8,... with DEB_PULSES=2 -> a single key_valid in the cycle after cycle 4, key_code=5, value=0x0005, num_digits=1. After release, no further key_valid.
REQ-034 Keys 1,2,3,4,5 then E, each press/release cleanly -> value=0x1234 before E, overflow=1 after key 5. On E: value_out=0x1234, value_valid one cycle, then value=0, num_digits=0, overflow=0.
REQ-035 Single isolated pulse for key 7, followed by 8 idle cycles -> no key_valid, FSM back to IDLE, buffer unchanged.
REQ-036 Pulses of 3 then 6 in CONFIRM, then 6 again -> accepted code 6 only, value=0x0006.
REQ-037 E with empty buffer -> key_valid=1, key_code=0xE, value_valid=0, value_out unchanged. Then keys 9, F -> value=0, value_out unchanged.
REQ-038 rst_n pulsed low while key 8 is HELD, key kept held -> all outputs 0 during reset. After reset, key 8 is accepted once, value=0x0008.

Source files
------------

// File: rtl/key_entry_if.sv
// key_entry_if: scanner-side key strobe and the debounced key/BCD entry results.
interface key_entry_if;
    logic [4:0]  digito;
    logic        cambio_digito;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic [2:0]  num_digits;
    logic        overflow;
    logic [15:0] value_out;
    logic        value_valid;

    modport master (
        output digito, cambio_digito,
        input  key_valid, key_code, value, num_digits, overflow, value_out, value_valid
    );
    modport slave (
        input  digito, cambio_digito,
        output key_valid, key_code, value, num_digits, overflow, value_out, value_valid
    );
endinterface

// File: rtl/key_entry.sv
// key_entry: debounces scanner key strobes and collects digits into a 4-digit BCD entry buffer.
module key_entry #(
    parameter int DEB_PULSES = 2,
    parameter int REL_CYCLES = 8
) (
    input logic        clk,
    input logic        rst_n,
    key_entry_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

    state_t      state, state_nx, cur;
    logic [3:0]  cand, cand_nx, idle_cnt, idle_nx;
    logic [2:0]  cnt, cnt_nx, num_nx;
    logic        pulse, expired, accept, ovf_nx, vv_nx;
    logic [15:0] value_nx, vo_nx;

    assign pulse   = bus.cambio_digito && bus.digito <= 5'd15;
    assign expired = idle_cnt == 4'(REL_CYCLES);
    // A saturated idle counter means the key is gone: behave as IDLE this cycle.
    assign cur     = (state != IDLE && expired) ? IDLE : state;
    assign idle_nx = pulse ? 4'd0 : expired ? idle_cnt : idle_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cand            <= 4'd0;
            cnt             <= 3'd0;
            idle_cnt        <= 4'd0;
            bus.key_valid   <= 1'b0;
            bus.key_code    <= 4'd0;
            bus.value       <= 16'd0;
            bus.num_digits  <= 3'd0;
            bus.overflow    <= 1'b0;
            bus.value_out   <= 16'd0;
            bus.value_valid <= 1'b0;
        end else begin
            state           <= state_nx;
            cand            <= cand_nx;
            cnt             <= cnt_nx;
            idle_cnt        <= idle_nx;
            bus.key_valid   <= accept;
            bus.key_code    <= accept ? cand_nx : bus.key_code;
            bus.value       <= value_nx;
            bus.num_digits  <= num_nx;
            bus.overflow    <= ovf_nx;
            bus.value_out   <= vo_nx;
            bus.value_valid <= vv_nx;
        end
    end

    always_comb begin
        state_nx = cur;
        cand_nx  = cand;
        cnt_nx   = cnt;
        accept   = 1'b0;
        if (pulse && cur == IDLE) begin
            cand_nx  = bus.digito[3:0];
            cnt_nx   = 3'd1;
            accept   = DEB_PULSES == 1;
            state_nx = accept ? HELD : CONFIRM;
        end else if (pulse && cur == CONFIRM) begin
            if (bus.digito[3:0] == cand) begin
                cnt_nx = cnt + 3'd1;
                accept = cnt_nx == 3'(DEB_PULSES);
            end else begin
                cand_nx = bus.digito[3:0];
                cnt_nx  = 3'd1;
            end
            state_nx = accept ? HELD : CONFIRM;
        end
    end

    always_comb begin
        value_nx = bus.value;
        num_nx   = bus.num_digits;
        ovf_nx   = bus.overflow;
        vo_nx    = bus.value_out;
        vv_nx    = 1'b0;
        if (accept && cand_nx <= 4'd9) begin
            if (bus.num_digits == 3'd4) begin
                ovf_nx = 1'b1;
            end else begin
                value_nx = {bus.value[11:0], cand_nx};
                num_nx   = bus.num_digits + 3'd1;
            end
        end else if (accept && ((cand_nx == 4'hE && bus.num_digits != 3'd0) || cand_nx == 4'hF)) begin
            vv_nx    = cand_nx == 4'hE;
            vo_nx    = vv_nx ? bus.value : bus.value_out;
            value_nx = 16'd0;
            num_nx   = 3'd0;
            ovf_nx   = 1'b0;
        end
    end
endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: directed key sequences checked every cycle against a behavioural keypad model.
module tb_key_entry;
    localparam int DEB = 2;
    localparam int REL = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int n_kv = 0;
    int n_vv = 0;

    key_entry_if bus();
    key_entry #(.DEB_PULSES(DEB), .REL_CYCLES(REL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Model: phase 0 waiting, 1 confirming, 2 held; since = non-pulse cycles since last pulse.
    int m_phase = 0, m_cand = 0, m_n = 0, m_since = 0;
    int q[$];
    logic        e_kv = 0, e_ovf = 0, e_vv = 0;
    logic [3:0]  e_kc = 0;
    logic [15:0] e_val = 0, e_vo = 0;
    logic [2:0]  e_num = 0;

    function automatic logic [15:0] pack(input int d[$]);
        logic [15:0] r = 0;
        foreach (d[i]) r = {r[11:0], 4'(d[i])};
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_cand = 0; m_n = 0; m_since = 0; q.delete();
            e_kv = 0; e_kc = 0; e_val = 0; e_num = 0; e_ovf = 0; e_vo = 0; e_vv = 0;
        end else begin
            automatic bit p = bus.cambio_digito && bus.digito <= 15;
            automatic bit acc = 0;
            automatic int ph = (m_since >= REL) ? 0 : m_phase;
            automatic int d = int'(bus.digito);
            if (p) begin
                m_since = 0;
                if (ph == 0) begin
                    m_cand = d; m_n = 1; acc = (m_n == DEB); ph = acc ? 2 : 1;
                end else if (ph == 1) begin
                    if (d == m_cand) begin
                        m_n++; acc = (m_n == DEB); ph = acc ? 2 : 1;
                    end else begin
                        m_cand = d; m_n = 1;
                    end
                end
            end else m_since++;
            m_phase = ph;
            e_kv = acc; e_vv = 0;
            if (acc) begin
                e_kc = 4'(m_cand);
                if (m_cand <= 9) begin
                    if (q.size() < 4) q.push_back(m_cand); else e_ovf = 1;
                end else if (m_cand == 14 && q.size() > 0) begin
                    e_vo = pack(q); e_vv = 1; q.delete(); e_ovf = 0;
                end else if (m_cand == 15) begin
                    q.delete(); e_ovf = 0;
                end
            end
            e_val = pack(q);
            e_num = 3'(q.size());
        end
    end

    always @(negedge clk) begin
        automatic logic [41:0] act = {bus.key_valid, bus.key_code, bus.value, bus.num_digits,
                                      bus.overflow, bus.value_out, bus.value_valid};
        automatic logic [41:0] exp = {e_kv, e_kc, e_val, e_num, e_ovf, e_vo, e_vv};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_compare t=%0t got=%h want=%h", $time, act, exp);
        end
        if (bus.key_valid === 1'b1) n_kv++;
        if (bus.value_valid === 1'b1) n_vv++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic [4:0] d);
        bus.cambio_digito = c;
        bus.digito = d;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] d, input int pulses);
        repeat (pulses) begin
            step(1, d);
            repeat (3) step(0, d);
        end
        repeat (12) step(0, 5'd16);
    endtask

    initial begin
        int k;
        bus.cambio_digito = 0;
        bus.digito = 5'd16;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step(0, 5'd16);
        check("reset_value", 32'(bus.value), 32'h0);

        press(5, 3);
        check("hold5_kv", n_kv, 1);
        check("hold5_code", 32'(bus.key_code), 32'h5);
        check("hold5_value", 32'(bus.value), 32'h5);
        check("hold5_num", 32'(bus.num_digits), 1);

        press(15, 2);
        for (int i = 1; i <= 4; i++) press(5'(i), 2);
        check("seq_value", 32'(bus.value), 32'h1234);
        check("seq_num", 32'(bus.num_digits), 4);
        press(5, 2);
        check("seq_ovf", 32'(bus.overflow), 1);
        check("seq_full_value", 32'(bus.value), 32'h1234);
        press(14, 2);
        check("enter_vv", n_vv, 1);
        check("enter_vo", 32'(bus.value_out), 32'h1234);
        check("enter_value", 32'(bus.value), 0);
        check("enter_ovf", 32'(bus.overflow), 0);

        k = n_kv;
        step(1, 7);
        repeat (REL) step(0, 5'd16);
        step(1, 7);
        repeat (12) step(0, 5'd16);
        check("glitch_kv", n_kv, k);
        check("glitch_value", 32'(bus.value), 0);

        step(1, 3); repeat (3) step(0, 3);
        step(1, 6); repeat (3) step(0, 6);
        step(1, 6); repeat (12) step(0, 5'd16);
        check("switch_kv", n_kv, k + 1);
        check("switch_code", 32'(bus.key_code), 32'h6);
        check("switch_value", 32'(bus.value), 32'h6);

        press(15, 2);
        press(14, 2);
        check("empty_enter_code", 32'(bus.key_code), 32'hE);
        check("empty_enter_vv", n_vv, 1);
        check("empty_enter_vo", 32'(bus.value_out), 32'h1234);
        press(9, 2);
        press(15, 2);
        check("clear_value", 32'(bus.value), 0);
        check("clear_vo", 32'(bus.value_out), 32'h1234);

        step(1, 8); repeat (3) step(0, 8);
        step(1, 8); step(0, 8);
        k = n_kv;
        check("held8_value", 32'(bus.value), 32'h8);
        #2 rst_n = 0;
        #1;
        check("rst_value", 32'(bus.value), 0);
        check("rst_vo", 32'(bus.value_out), 0);
        step(0, 8); step(1, 8); step(0, 8);
        rst_n = 1;
        repeat (3) begin
            step(0, 8); step(0, 8); step(1, 8); step(0, 8);
        end
        repeat (12) step(0, 5'd16);
        check("rst_reaccept_kv", n_kv, k + 1);
        check("rst_reaccept_value", 32'(bus.value), 32'h8);
        check("rst_reaccept_num", 32'(bus.num_digits), 1);

        step(1, 2); repeat (3) step(0, 2);
        step(1, 2);
        repeat (REL) step(0, 5'd16);
        step(1, 2); repeat (3) step(0, 2);
        step(1, 2);
        repeat (REL - 1) step(0, 5'd16);
        step(1, 2); repeat (3) step(0, 2);
        step(1, 2);
        repeat (12) step(0, 5'd16);
        check("boundary_kv", n_kv, k + 3);
        check("boundary_value", 32'(bus.value), 32'h822);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
